vm1_rfctl: RTL and testbench

Register-file access controller for the VM1 core's 64×16 dual-port register/vector RAM. It owns port B of the RAM (word-wide write, no byte enables) and serves read, word-write and byte-write requests from the debug/microcode side over a valid/ready handshake. It hides the RAM's one-cycle synchronous read latency and synthesises byte writes by read-modify-write. After reset it clears the whole array before accepting traffic.

---
 rtl/vm1_rf_pkg.sv | 21 ++
 rtl/vm1_rfctl.sv | 135 +++++++++++++
 tb/tb_vm1_rfctl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vm1_rf_pkg.sv
// Shared definitions for the VM1 register-file port-B controller:
// controller states, array depth and the byte-lane merge used by byte writes.
package vm1_rf_pkg;

  typedef enum logic [1:0] {
    RF_INIT = 2'd0,
    RF_IDLE = 2'd1,
    RF_RMW  = 2'd2
  } rf_state_e;

  localparam int RF_DEPTH = 64;

  // Lane-select merge: be[0] picks bits 7:0 from new_w, be[1] picks bits 15:8.
  function automatic logic [15:0] rf_lane_merge(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic [1:0]  be);
    rf_lane_merge = {be[1] ? new_w[15:8] : old_w[15:8],
                     be[0] ? new_w[7:0]  : old_w[7:0]};
  endfunction

endpackage

// File: rtl/vm1_rfctl.sv
// Port-B access controller for the VM1 64x16 register/vector RAM: clears the
// array after reset, then serves reads, word writes and read-modify-write byte writes.
module vm1_rfctl
  import vm1_rf_pkg::*;
#(
  parameter int AW         = 6,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_be,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          rsp_valid,
  output logic [15:0]   rsp_data,
  output logic          init_busy,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_data,
  output logic          ram_wren,
  input  logic [15:0]   ram_q
);

  localparam rf_state_e     RESET_STATE = INIT_CLEAR ? RF_INIT : RF_IDLE;
  localparam logic [AW-1:0] CLR_LAST    = {AW{1'b1}};

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rd_pend_q, rd_pend_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          wren_c;
  logic          accept;
  logic [15:0]   merged;

  assign req_ready = (state_q == RF_IDLE);
  assign init_busy = (state_q == RF_INIT);
  assign accept    = req_valid & req_ready;
  assign merged    = rf_lane_merge(ram_q, wdata_q, be_q);

  // A read response is the RAM output itself in the cycle after the address edge.
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rd_pend_q ? ram_q : rsp_data_q;

  // The state register sits in INIT while reset is held, so the write strobe
  // is gated to keep the RAM untouched until reset is released.
  assign ram_wren  = wren_c & reset_n;

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rd_pend_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    wren_c      = 1'b0;
    ram_addr    = '0;
    ram_data    = '0;

    unique case (state_q)
      RF_INIT: begin
        wren_c   = 1'b1;
        ram_addr = clr_q;
        clr_d    = clr_q + AW'(1);
        if (clr_q == CLR_LAST) begin
          state_d = RF_IDLE;
        end
      end

      RF_IDLE: begin
        ram_addr = req_addr;
        ram_data = req_wdata;
        if (accept) begin
          if (req_we && (req_be == 2'b11)) begin
            wren_c      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = req_wdata;
          end else if (req_we && (req_be != 2'b00)) begin
            // Single-lane write: the read issued now feeds the merge next cycle.
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            state_d = RF_RMW;
          end else begin
            rsp_valid_d = 1'b1;
            rd_pend_d   = 1'b1;
          end
        end
      end

      RF_RMW: begin
        wren_c      = 1'b1;
        ram_addr    = addr_q;
        ram_data    = merged;
        rsp_valid_d = 1'b1;
        rsp_data_d  = merged;
        state_d     = RF_IDLE;
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rd_pend_q   <= rd_pend_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

endmodule

// File: tb/tb_vm1_rfctl.sv
// Bench for vm1_rfctl: bench-side RAM, a cycle-level reference model of the
// request/response contract, directed scenarios and a randomized request stream.
module tb_vm1_rfctl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [1:0]  req_be;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        init_busy;
  logic [5:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;

  vm1_rfctl #(.AW(6), .INIT_CLEAR(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_busy(init_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side port-B RAM with a backdoor loader used only while reset is held.
  logic [15:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic        bad7 = 1'b0;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      if (ram_addr == 6'd7 && ram_data == 16'h00AB) bad7 <= 1'b1;
    end
    ram_q <= mem[ram_addr];
  end

  // Reference model: array contents, init countdown, pending merge, response schedule.
  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] model_mem [64];
  logic [15:0] rsp_at [int];
  int          init_left = 64;
  bit          rmw_pend  = 0;
  logic [5:0]  rmw_addr;
  logic [15:0] rmw_data;
  logic [15:0] mask, mrg;
  bit          exp_ready;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_init_busy", 32'(init_busy), 1);
      check("rst_wren", 32'(ram_wren), 0);
      init_left = 64;
      rmw_pend  = 0;
      exp_q.delete();
    end else begin
      exp_ready = (init_left == 0) && !rmw_pend;
      check("ready", 32'(req_ready), 32'(exp_ready));
      check("init_busy", 32'(init_busy), 32'(init_left > 0));
      if (rsp_valid) rsp_at[cyc] = rsp_data;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 0);
      end
      if (init_left > 0) begin
        check("init_wren", 32'(ram_wren), 1);
        check("init_addr", 32'(ram_addr), 32'(64 - init_left));
        check("init_data", 32'(ram_data), 0);
        model_mem[64 - init_left] = 16'h0000;
        init_left--;
      end else if (rmw_pend) begin
        check("rmw_wren", 32'(ram_wren), 1);
        check("rmw_addr", 32'(ram_addr), 32'(rmw_addr));
        check("rmw_data", 32'(ram_data), 32'(rmw_data));
        model_mem[rmw_addr] = rmw_data;
        rmw_pend = 0;
      end else if (req_valid) begin
        check("acc_addr", 32'(ram_addr), 32'(req_addr));
        if (req_we && req_be == 2'b11) begin
          check("ww_wren", 32'(ram_wren), 1);
          check("ww_data", 32'(ram_data), 32'(req_wdata));
          model_mem[req_addr] = req_wdata;
          exp_q.push_back('{cyc + 1, req_wdata});
        end else if (req_we && req_be != 2'b00) begin
          check("bw_wren", 32'(ram_wren), 0);
          mask = (req_be[1] ? 16'hFF00 : 16'h0000) | (req_be[0] ? 16'h00FF : 16'h0000);
          mrg  = (req_wdata & mask) | (model_mem[req_addr] & ~mask);
          rmw_pend = 1;
          rmw_addr = req_addr;
          rmw_data = mrg;
          exp_q.push_back('{cyc + 2, mrg});
        end else begin
          check("rd_wren", 32'(ram_wren), 0);
          exp_q.push_back('{cyc + 1, model_mem[req_addr]});
        end
      end else begin
        check("idle_wren", 32'(ram_wren), 0);
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic issue(input logic we, input logic [1:0] be, input logic [5:0] a,
                       input logic [15:0] wd, output int acc, output logic wr_at);
    bit got = 0;
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_wdata = wd;
    acc = -1; wr_at = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      if (req_ready) begin got = 1; acc = cyc; wr_at = ram_wren; end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic expect_rsp(input string nm, input int due, input logic [15:0] exp);
    for (int k = 0; k < 20 && cyc <= due; k++) @(posedge clock);
    #1;
    if (rsp_at.exists(due)) check(nm, 32'(rsp_at[due]), 32'(exp));
    else check({nm, "_missing"}, 0, 1);
  endtask

  task automatic wait_init(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!init_busy) break;
      busy_cycles++;
    end
    @(posedge clock); #1;
  endtask

  int          a0, a1, n_init;
  int          acc4 [4];
  logic        wr;
  bit          accepted_now;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00;
    req_addr = '0; req_wdata = '0;
    @(posedge clock); #1;
    check("reset_ram_addr", 32'(ram_addr), 0);
    check("reset_ram_data", 32'(ram_data), 0);
    check("reset_ready", 32'(req_ready), 0);
    check("reset_init_busy", 32'(init_busy), 1);
    for (int i = 0; i < 64; i++) begin
      bd_we = 1'b1; bd_addr = 6'(i); bd_data = 16'(($urandom & 16'hFFFF) | 16'h0001);
      @(posedge clock); #1;
    end
    bd_we = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    wait_init(n_init);
    check("init_cycles", 32'(n_init), 64);
    check("clear_mem17_array", 32'(mem[17]), 0);

    issue(1'b0, 2'b00, 6'd0, 16'h0, a0, wr);  expect_rsp("rd0_after_init", a0 + 1, 16'h0000);
    issue(1'b0, 2'b00, 6'd17, 16'h0, a0, wr); expect_rsp("rd17_after_init", a0 + 1, 16'h0000);
    issue(1'b0, 2'b00, 6'd63, 16'h0, a0, wr); expect_rsp("rd63_after_init", a0 + 1, 16'h0000);

    issue(1'b1, 2'b11, 6'd5, 16'hA55A, a0, wr);
    issue(1'b0, 2'b00, 6'd5, 16'h0000, a1, wr);
    check("raw_back_to_back", 32'(a1), 32'(a0 + 1));
    expect_rsp("word_write_rsp", a0 + 1, 16'hA55A);
    expect_rsp("raw_read_rsp", a1 + 1, 16'hA55A);

    issue(1'b1, 2'b11, 6'd9, 16'h1234, a0, wr);
    issue(1'b1, 2'b10, 6'd9, 16'hBEEF, a0, wr);
    @(negedge clock); check("bw_ready_low", 32'(req_ready), 0);
    @(negedge clock); check("bw_ready_back", 32'(req_ready), 1);
    @(posedge clock); #1;
    expect_rsp("byte_write_rsp", a0 + 2, 16'hBE34);
    check("byte_write_ram", 32'(mem[9]), 32'h0000BE34);

    for (int i = 0; i < 4; i++) issue(1'b1, 2'b11, 6'(i), 16'(i + 1), a0, wr);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'b00, 6'(i), 16'h0, acc4[i], wr);
    for (int i = 1; i < 4; i++) check("b2b_accept", 32'(acc4[i]), 32'(acc4[0] + i));
    for (int i = 0; i < 4; i++) expect_rsp("b2b_read", acc4[0] + i + 1, 16'(i + 1));

    issue(1'b1, 2'b11, 6'd3, 16'h0042, a0, wr);
    issue(1'b1, 2'b00, 6'd3, 16'hFFFF, a0, wr);
    check("be00_no_wren", 32'(wr), 0);
    expect_rsp("be00_rsp", a0 + 1, 16'h0042);

    issue(1'b1, 2'b11, 6'd7, 16'h00FF, a0, wr);
    issue(1'b1, 2'b01, 6'd7, 16'h12AB, a0, wr);
    reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("reinit_addr0", 32'(ram_addr), 0);
    check("reinit_wren", 32'(ram_wren), 1);
    wait_init(n_init);
    check("reinit_cycles", 32'(n_init), 63);
    check("abort_no_merge_write", 32'(bad7), 0);
    issue(1'b0, 2'b00, 6'd7, 16'h0, a0, wr); expect_rsp("rd7_after_abort", a0 + 1, 16'h0000);

    accepted_now = 0;
    for (int i = 0; i < 400; i++) begin
      if (!req_valid || accepted_now) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_we    = $urandom_range(0, 1) == 1;
        req_be    = 2'($urandom_range(0, 3));
        req_addr  = 6'($urandom_range(0, 15));
        req_wdata = 16'($urandom);
      end
      @(negedge clock); accepted_now = req_valid && req_ready;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    for (int i = 0; i < 64; i++) check("final_mem", 32'(mem[i]), 32'(model_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
